icache_data_array: RTL and testbench

Parametrised N-way instruction-cache data array with a built-in line-refill sequencer. Holds `WAYS` ways of `SETS` lines of `LINE_WORDS` 32-bit words. Provides a one-cycle registered read of all ways in parallel, with same-cycle write-to-read bypass, for the fetch stage's way select. Accepts critical-word-first refill bursts from the AXI miss handler and writes them beat by beat into one victim way.

---
 rtl/icache_pkg.sv | 28 ++
 rtl/icache_data_bank.sv | 26 ++
 rtl/icache_data_array.sv | 150 +++++++++++++++
 tb/tb_icache_data_array.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
`default_nettype none
// == icache_pkg : defaults, width helpers and refill FSM encoding for the I$ data array | rev 1.0 ==
package icache_pkg;

  localparam int DEF_WAYS       = 2;
  localparam int DEF_SETS       = 128;
  localparam int DEF_LINE_WORDS = 8;

  function automatic int index_width(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int offset_width(input int line_words);
    return $clog2(line_words);
  endfunction

  // A single-way array still carries a 1-bit way field so port widths never collapse to zero.
  function automatic int way_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } refill_state_e;

endpackage
`default_nettype wire

// File: rtl/icache_data_bank.sv
`default_nettype none
// == icache_data_bank : one cache way, single write port, asynchronous read | rev 1.0 ==
module icache_data_bank #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/icache_data_array.sv
`default_nettype none
// == icache_data_array : N-way I$ data array with critical-word-first refill sequencer | rev 1.0 ==
module icache_data_array
  import icache_pkg::*;
#(
  parameter  int WAYS       = DEF_WAYS,
  parameter  int SETS       = DEF_SETS,
  parameter  int LINE_WORDS = DEF_LINE_WORDS,
  localparam int IW         = index_width(SETS),
  localparam int OW         = offset_width(LINE_WORDS),
  localparam int WW         = way_width(WAYS)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rd_en,
  input  logic [IW-1:0]     rd_index,
  input  logic [OW-1:0]     rd_offset,
  output logic [WAYS*32-1:0] rd_data,
  output logic              rd_valid,
  input  logic              refill_start,
  input  logic [WW-1:0]     refill_way,
  input  logic [IW-1:0]     refill_index,
  input  logic [OW-1:0]     refill_offset,
  input  logic              refill_valid,
  input  logic [31:0]       refill_data,
  output logic              refill_ready,
  output logic              refill_busy,
  output logic              refill_done
);

  localparam int            AW        = IW + OW;
  localparam logic [OW-1:0] LAST_BEAT = OW'(LINE_WORDS - 1);

  refill_state_e      state_q, state_d;
  logic [OW-1:0]      cnt_q, cnt_d;
  logic [WW-1:0]      way_q, way_d;
  logic [IW-1:0]      index_q, index_d;
  logic [OW-1:0]      offset_q, offset_d;
  logic               done_q, done_d;
  logic [WAYS*32-1:0] rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;

  logic               xfer;
  logic [OW-1:0]      wr_offset;
  logic [AW-1:0]      wr_addr;
  logic [AW-1:0]      rd_addr;
  logic               bypass_addr;
  logic [31:0]        ram_word  [WAYS];
  logic [31:0]        next_word [WAYS];

  assign xfer        = refill_valid && (state_q == FILL);
  // Offset arithmetic wraps at the line boundary because LINE_WORDS is a power of two.
  assign wr_offset   = offset_q + cnt_q;
  assign wr_addr     = {index_q, wr_offset};
  assign rd_addr     = {rd_index, rd_offset};
  assign bypass_addr = rd_en && xfer && (index_q == rd_index) && (wr_offset == rd_offset);

  generate
    for (genvar w = 0; w < WAYS; w++) begin : g_way
      logic way_sel;
      assign way_sel = (way_q == WW'(w));

      icache_data_bank #(
        .DEPTH (SETS * LINE_WORDS),
        .AW    (AW)
      ) u_bank (
        .clk   (clk),
        .we    (xfer && way_sel),
        .waddr (wr_addr),
        .wdata (refill_data),
        .raddr (rd_addr),
        .rdata (ram_word[w])
      );

      // The bank write lands at the edge, so a same-cycle read must see the beat directly.
      assign next_word[w] = (bypass_addr && way_sel) ? refill_data : ram_word[w];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    way_d    = way_q;
    index_d  = index_q;
    offset_d = offset_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (refill_start) begin
          state_d  = FILL;
          way_d    = refill_way;
          index_d  = refill_index;
          offset_d = refill_offset;
          cnt_d    = '0;
        end
      end
      FILL: begin
        if (xfer) begin
          cnt_d = cnt_q + OW'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
      for (int w = 0; w < WAYS; w++) begin
        rd_data_d[32*w +: 32] = next_word[w];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      way_q      <= '0;
      index_q    <= '0;
      offset_q   <= '0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      way_q      <= way_d;
      index_q    <= index_d;
      offset_q   <= offset_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign refill_ready = (state_q == FILL);
  assign refill_busy  = (state_q == FILL);
  assign refill_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_icache_data_array.sv
`default_nettype none
// == tb_icache_data_array : directed self-checking bench for icache_data_array | rev 1.0 ==
module tb_icache_data_array;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rd_en;
  logic [6:0]  rd_index;
  logic [2:0]  rd_offset;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        refill_start;
  logic [0:0]  refill_way;
  logic [6:0]  refill_index;
  logic [2:0]  refill_offset;
  logic        refill_valid;
  logic [31:0] refill_data;
  logic        refill_ready;
  logic        refill_busy;
  logic        refill_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  icache_data_array #(
    .WAYS       (2),
    .SETS       (128),
    .LINE_WORDS (8)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .rd_en         (rd_en),
    .rd_index      (rd_index),
    .rd_offset     (rd_offset),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .refill_start  (refill_start),
    .refill_way    (refill_way),
    .refill_index  (refill_index),
    .refill_offset (refill_offset),
    .refill_valid  (refill_valid),
    .refill_data   (refill_data),
    .refill_ready  (refill_ready),
    .refill_busy   (refill_busy),
    .refill_done   (refill_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Consecutive-beat refill; returns with the done pulse visible and no trailing cycle.
  task automatic do_refill(input logic [0:0] way, input logic [6:0] idx,
                           input logic [2:0] off, input logic [31:0] base);
    refill_start  = 1'b1;
    refill_way    = way;
    refill_index  = idx;
    refill_offset = off;
    tick();
    refill_start = 1'b0;
    check("start_ready", 64'(refill_ready), 64'd1);
    for (int k = 0; k < 8; k++) begin
      refill_valid = 1'b1;
      refill_data  = base + 32'(k);
      tick();
      check("burst_done", 64'(refill_done), (k == 7) ? 64'd1 : 64'd0);
    end
    refill_valid = 1'b0;
    check("burst_end_busy", 64'(refill_busy), 64'd0);
  endtask

  task automatic read_word(input logic [6:0] idx, input logic [2:0] off);
    rd_en     = 1'b1;
    rd_index  = idx;
    rd_offset = off;
    tick();
    rd_en = 1'b0;
    check("read_valid", 64'(rd_valid), 64'd1);
  endtask

  initial begin
    logic [63:0] exp;

    // Reset with random inputs
    resetn = 1'b0;
    for (int c = 0; c < 2; c++) begin
      rd_en         = 1'($urandom);
      rd_index      = 7'($urandom);
      rd_offset     = 3'($urandom);
      refill_start  = 1'($urandom);
      refill_way    = 1'($urandom);
      refill_index  = 7'($urandom);
      refill_offset = 3'($urandom);
      refill_valid  = 1'($urandom);
      refill_data   = $urandom;
      tick();
    end
    check("rst_rd_data", rd_data, 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_ready", 64'(refill_ready), 64'd0);
    check("rst_busy", 64'(refill_busy), 64'd0);
    check("rst_done", 64'(refill_done), 64'd0);

    resetn = 1'b1; rd_en = 1'b0; rd_index = '0; rd_offset = '0;
    refill_start = 1'b0; refill_way = '0; refill_index = '0; refill_offset = '0;
    refill_valid = 1'b0; refill_data = '0;
    tick();

    // Known contents in way 0, set 5: offset k holds 0xB0+k
    do_refill(1'b0, 7'd5, 3'd0, 32'hB0);
    tick();
    check("prefill_done_clear", 64'(refill_done), 64'd0);

    // Wrapped refill into way 1 with a bypassed read on the second beat
    refill_start = 1'b1; refill_way = 1'b1; refill_index = 7'd5; refill_offset = 3'd6;
    tick();
    refill_start = 1'b0;
    check("wrap_ready", 64'(refill_ready), 64'd1);
    check("wrap_busy", 64'(refill_busy), 64'd1);
    for (int k = 0; k < 8; k++) begin
      refill_valid = 1'b1;
      refill_data  = 32'hA0 + 32'(k);
      rd_en        = (k == 1);
      rd_index     = 7'd5;
      rd_offset    = 3'd7;
      tick();
      rd_en = 1'b0;
      if (k == 1) begin
        check("bypass_data", rd_data, 64'h000000A1_000000B7);
        check("bypass_valid", 64'(rd_valid), 64'd1);
      end
      check("wrap_done", 64'(refill_done), (k == 7) ? 64'd1 : 64'd0);
    end
    check("wrap_end_ready", 64'(refill_ready), 64'd0);
    refill_valid = 1'b0;
    tick();
    check("wrap_done_once", 64'(refill_done), 64'd0);

    for (int o = 0; o < 8; o++) begin
      read_word(7'd5, 3'(o));
      exp = {32'hA0 + 32'((o + 2) % 8), 32'hB0 + 32'(o)};
      check("wrap_readback", rd_data, exp);
    end

    // rd_en low holds the last result ({A1,B7} from offset 7)
    for (int c = 0; c < 5; c++) begin
      rd_index  = 7'(c * 3);
      rd_offset = 3'(c);
      tick();
      check("hold_data", rd_data, 64'h000000A1_000000B7);
    end
    check("hold_valid", 64'(rd_valid), 64'd0);

    // Stalled burst into way 0 set 9 offset 3, with an ignored start mid-fill
    refill_start = 1'b1; refill_way = 1'b0; refill_index = 7'd9; refill_offset = 3'd3;
    tick();
    refill_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      refill_valid = 1'b1;
      refill_data  = 32'hC0 + 32'(k);
      if (k == 2) begin
        refill_start = 1'b1; refill_way = 1'b1; refill_index = 7'd10; refill_offset = 3'd0;
      end
      tick();
      refill_start = 1'b0;
      refill_valid = 1'b0;
      refill_data  = 32'hDEADBEEF;
      if (k < 7) begin
        check("stall_done_beat", 64'(refill_done), 64'd0);
        tick();
        tick();
        check("stall_busy_gap", 64'(refill_busy), 64'd1);
        check("stall_done_gap", 64'(refill_done), 64'd0);
      end else begin
        check("stall_done_last", 64'(refill_done), 64'd1);
      end
    end
    tick();
    check("stall_idle_busy", 64'(refill_busy), 64'd0);
    for (int o = 0; o < 8; o++) begin
      read_word(7'd9, 3'(o));
      check("stall_readback", 64'(rd_data[31:0]), 64'(32'hC0 + 32'((o + 5) % 8)));
    end

    // Abort after three beats
    refill_start = 1'b1; refill_way = 1'b1; refill_index = 7'd20; refill_offset = 3'd2;
    tick();
    refill_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      refill_valid = 1'b1;
      refill_data  = 32'hD0 + 32'(k);
      tick();
    end
    resetn       = 1'b0;
    refill_data  = 32'hD3;
    tick();
    check("abort_busy", 64'(refill_busy), 64'd0);
    check("abort_ready", 64'(refill_ready), 64'd0);
    check("abort_done", 64'(refill_done), 64'd0);
    check("abort_rd_data", rd_data, 64'd0);
    resetn       = 1'b1;
    refill_valid = 1'b0;
    tick();
    check("abort_done_after", 64'(refill_done), 64'd0);
    do_refill(1'b1, 7'd20, 3'd2, 32'hE0);
    tick();
    read_word(7'd20, 3'd2);
    check("abort_restart_first", 64'(rd_data[63:32]), 64'h0E0);
    read_word(7'd20, 3'd5);
    check("abort_restart_fourth", 64'(rd_data[63:32]), 64'h0E3);

    // Back-to-back: second start coincides with the first done pulse
    do_refill(1'b0, 7'd30, 3'd0, 32'hF0);
    refill_start = 1'b1; refill_way = 1'b1; refill_index = 7'd30; refill_offset = 3'd4;
    tick();
    refill_start = 1'b0;
    check("b2b_ready", 64'(refill_ready), 64'd1);
    check("b2b_busy", 64'(refill_busy), 64'd1);
    check("b2b_done", 64'(refill_done), 64'd0);
    for (int k = 0; k < 8; k++) begin
      refill_valid = 1'b1;
      refill_data  = 32'h10 + 32'(k);
      tick();
    end
    refill_valid = 1'b0;
    check("b2b_second_done", 64'(refill_done), 64'd1);
    tick();
    read_word(7'd30, 3'd4);
    check("b2b_readback", rd_data, 64'h00000010_000000F4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
